// File: rtl/sparsity_if.sv
// sparsity_if: job control, dense input, compacted nonzero output and flag RAM write port of the sparsity encoder.
interface sparsity_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FLAG_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int GRP_WIDTH  = 8
);
    logic                          start;
    logic [GRP_WIDTH-1:0]          num_groups;
    logic                          in_valid;
    logic [DATA_WIDTH-1:0]         in_data;
    logic                          in_ready;
    logic                          nz_valid;
    logic [DATA_WIDTH-1:0]         nz_data;
    logic                          nz_ready;
    logic                          wr_req;
    logic [FLAG_WIDTH-1:0]         wr_data;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [$clog2(FLAG_WIDTH):0]   wr_nz_cnt;
    logic                          busy;
    logic                          done;

    modport master (
        output start, num_groups, in_valid, in_data, nz_ready,
        input  in_ready, nz_valid, nz_data, wr_req, wr_data, wr_addr, wr_nz_cnt, busy, done
    );

    modport slave (
        input  start, num_groups, in_valid, in_data, nz_ready,
        output in_ready, nz_valid, nz_data, wr_req, wr_data, wr_addr, wr_nz_cnt, busy, done
    );
endinterface

// File: rtl/sparsity_encoder.sv
// sparsity_encoder: packs a dense stream into per-group sparsity flag words (bit k = element k nonzero)
// written to the flag RAM, and forwards the nonzero elements in arrival order.
module sparsity_encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int FLAG_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int GRP_WIDTH  = 8
) (
    input logic       clk,
    input logic       reset,
    sparsity_if.slave bus
);
    localparam int CW = $clog2(FLAG_WIDTH);
    localparam int PW = CW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                state, state_nx;
    logic [FLAG_WIDTH-1:0] acc, word;
    logic [CW-1:0]         elem;
    logic [GRP_WIDTH-1:0]  grp, last_grp;
    logic [ADDR_WIDTH-1:0] addr;
    logic [PW-1:0]         pop;
    logic                  accept, elem_last, grp_last;

    assign bus.in_ready = (state == RUN) && (!bus.nz_valid || bus.nz_ready);
    assign bus.busy     = state != IDLE;
    assign bus.done     = state == DONE;
    assign accept       = bus.in_valid && bus.in_ready;
    assign elem_last    = elem == CW'(FLAG_WIDTH - 1);
    assign grp_last     = grp == last_grp;
    // word includes the element being accepted so a completed group is written without an extra cycle
    assign word         = acc | (FLAG_WIDTH'(|bus.in_data) << elem);

    always_comb begin
        pop = '0;
        for (int i = 0; i < FLAG_WIDTH; i++) pop = pop + PW'(word[i]);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !bus.start ? IDLE : (bus.num_groups != '0 ? RUN : DONE);
            RUN:     state_nx = accept && elem_last && grp_last ? FLUSH : RUN;
            FLUSH:   state_nx = !bus.nz_valid && !bus.wr_req ? DONE : FLUSH;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc           <= '0;
            elem          <= '0;
            grp           <= '0;
            last_grp      <= '0;
            addr          <= '0;
            bus.nz_valid  <= 1'b0;
            bus.nz_data   <= '0;
            bus.wr_req    <= 1'b0;
            bus.wr_data   <= '0;
            bus.wr_addr   <= '0;
            bus.wr_nz_cnt <= '0;
        end else begin
            bus.wr_req <= 1'b0;
            if (state == IDLE && bus.start) begin
                acc      <= '0;
                elem     <= '0;
                grp      <= '0;
                addr     <= '0;
                last_grp <= bus.num_groups - 1'b1;
            end
            if (accept) begin
                acc  <= elem_last ? '0 : word;
                elem <= elem_last ? '0 : elem + 1'b1;
            end
            if (accept && elem_last) begin
                bus.wr_req    <= 1'b1;
                bus.wr_data   <= word;
                bus.wr_nz_cnt <= pop;
                bus.wr_addr   <= addr;
                addr          <= addr + 1'b1;
                grp           <= grp + 1'b1;
            end
            // in_ready guarantees a held element is never overwritten before it is popped
            if (accept && |bus.in_data) begin
                bus.nz_valid <= 1'b1;
                bus.nz_data  <= bus.in_data;
            end else if (bus.nz_ready) begin
                bus.nz_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sparsity_encoder.sv
// tb_sparsity_encoder: random and directed jobs checked against a queue-based model of flag words and nonzero stream.
module tb_sparsity_encoder;
    localparam int DW = 8, FW = 16, AW = 4, GW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sparsity_if #(.DATA_WIDTH(DW), .FLAG_WIDTH(FW), .ADDR_WIDTH(AW), .GRP_WIDTH(GW)) bus ();

    sparsity_encoder #(.DATA_WIDTH(DW), .FLAG_WIDTH(FW), .ADDR_WIDTH(AW), .GRP_WIDTH(GW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {int w; int c; int a;} wr_t;

    int total = 0, bad = 0;
    int cyc = 0, n_acc = 0, wr_n = 0, nz_n = 0, done_n = 0, last_wr_cyc = 0, rdy_mode = 0;
    int last_wr = 0, last_cnt = 0, last_addr = 0;
    bit gap_chk = 0;
    logic [FW-1:0] bits;
    wr_t wq[$];
    int nzq[$];
    wr_t e;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // nz_ready: 0 = always ready, 1 = random, 2 = held low
    initial begin
        bus.nz_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.nz_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // reference model: flag word of a group = sum of 2**k over nonzero element positions k
    always @(negedge clk) begin
        if (reset) begin
            cyc++;
            if (bus.in_valid && bus.in_ready) begin
                bits[n_acc % FW] = bus.in_data != 0;
                if (bus.in_data != 0) nzq.push_back(int'(bus.in_data));
                if (n_acc % FW == FW - 1) begin
                    e.w = 0;
                    e.c = 0;
                    for (int i = 0; i < FW; i++) if (bits[i]) begin e.w += 1 << i; e.c++; end
                    e.a = (n_acc / FW) % (1 << AW);
                    wq.push_back(e);
                end
                n_acc++;
            end
            if (bus.nz_valid && !bus.nz_ready) chk("stall_in_ready", bus.in_ready, 0);
            if (bus.nz_valid && bus.nz_ready) begin
                nz_n++;
                if (nzq.size() == 0) chk("nz_extra", 1, 0);
                else chk("nz_data", bus.nz_data, nzq.pop_front());
            end
            if (bus.wr_req) begin
                if (gap_chk && wr_n > 0) chk("wr_gap", cyc - last_wr_cyc, 16);
                last_wr_cyc = cyc;
                last_wr = int'(bus.wr_data);
                last_cnt = int'(bus.wr_nz_cnt);
                last_addr = int'(bus.wr_addr);
                wr_n++;
                if (wq.size() == 0) chk("wr_extra", 1, 0);
                else begin
                    e = wq.pop_front();
                    chk("wr_data", bus.wr_data, e.w);
                    chk("wr_nz_cnt", bus.wr_nz_cnt, e.c);
                    chk("wr_addr", bus.wr_addr, e.a);
                end
            end
            if (bus.done) done_n++;
        end
    end

    task automatic push(logic [DW-1:0] v, int gap);
        int n = 0;
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data = v;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin n++; @(negedge clk); end
        if (n >= 200) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic start_job(int ng);
        n_acc = 0; wr_n = 0; nz_n = 0; done_n = 0;
        bus.num_groups = GW'(ng);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.done && n < 3000);
        chk({tag, "_done"}, bus.done, 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, bus.done, 0);
        chk({tag, "_idle"}, bus.busy, 0);
        chk({tag, "_nz_left"}, nzq.size(), 0);
        chk({tag, "_wr_left"}, wq.size(), 0);
        chk({tag, "_done_n"}, done_n, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_nz_valid"}, bus.nz_valid, 0);
        chk({tag, "_nz_data"}, bus.nz_data, 0);
        chk({tag, "_wr_req"}, bus.wr_req, 0);
        chk({tag, "_wr_data"}, bus.wr_data, 0);
        chk({tag, "_wr_addr"}, bus.wr_addr, 0);
        chk({tag, "_wr_nz_cnt"}, bus.wr_nz_cnt, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
    endtask

    initial begin
        logic [DW-1:0] t1 [FW];
        int ng, n;
        bus.start = 1'b0; bus.num_groups = '0; bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1; reset = 1'b1;

        // flag bits 1,4,15 set
        for (int i = 0; i < FW; i++) t1[i] = '0;
        t1[1] = 7; t1[4] = 9; t1[15] = 1;
        start_job(1);
        for (int i = 0; i < FW; i++) push(t1[i], 0);
        wait_done("t1");
        chk("t1_word", last_wr, 32'h8012);
        chk("t1_cnt", last_cnt, 3);
        chk("t1_addr", last_addr, 0);
        chk("t1_nz_n", nz_n, 3);

        start_job(1);
        for (int i = 0; i < FW; i++) push(0, i % 2);
        wait_done("t2");
        chk("t2_word", last_wr, 0);
        chk("t2_cnt", last_cnt, 0);
        chk("t2_nz_n", nz_n, 0);
        chk("t2_wr_n", wr_n, 1);

        rdy_mode = 2;
        start_job(2);
        fork
            for (int i = 1; i <= 32; i++) push(DW'(i), 0);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (!bus.nz_valid && n < 100);
                repeat (5) @(posedge clk);
                rdy_mode = 0;
            end
        join
        wait_done("t3");
        chk("t3_word", last_wr, 32'hFFFF);
        chk("t3_cnt", last_cnt, 16);
        chk("t3_addr", last_addr, 1);
        chk("t3_nz_n", nz_n, 32);

        gap_chk = 1;
        start_job(17);
        for (int i = 0; i < 17 * FW; i++) push($urandom_range(0, 3) == 0 ? '0 : DW'($urandom), 0);
        wait_done("t4");
        gap_chk = 0;
        chk("t4_wr_n", wr_n, 17);
        chk("t4_last_addr", last_addr, 0);

        start_job(1);
        for (int i = 0; i < 7; i++) push(DW'(i + 1), 0);
        reset = 1'b0;
        #1;
        check_zero("t5_reset");
        nzq.delete();
        wq.delete();
        @(posedge clk); #1; reset = 1'b1;
        start_job(1);
        for (int i = 0; i < FW; i++) push(DW'($urandom), 0);
        wait_done("t5");
        chk("t5_wr_n", wr_n, 1);
        chk("t5_addr", last_addr, 0);

        start_job(0);
        @(negedge clk);
        chk("t6_busy", bus.busy, 1);
        chk("t6_done", bus.done, 1);
        @(negedge clk);
        chk("t6_busy_after", bus.busy, 0);
        chk("t6_done_after", bus.done, 0);
        chk("t6_done_n", done_n, 1);
        chk("t6_wr_n", wr_n, 0);
        @(posedge clk); #1;

        // start pulses during RUN must not change the group count
        start_job(2);
        for (int i = 0; i < 5; i++) push(DW'($urandom), 0);
        bus.num_groups = 1; bus.start = 1'b1;
        for (int i = 0; i < 5; i++) push(DW'($urandom), 0);
        bus.start = 1'b0;
        for (int i = 0; i < 22; i++) push(DW'($urandom), 0);
        wait_done("t6b");
        chk("t6b_wr_n", wr_n, 2);

        rdy_mode = 1;
        for (int j = 0; j < 4; j++) begin
            ng = $urandom_range(1, 3);
            start_job(ng);
            for (int i = 0; i < ng * FW; i++) push($urandom_range(0, 1) == 0 ? '0 : DW'($urandom), $urandom_range(0, 2));
            wait_done("rnd");
            chk("rnd_wr_n", wr_n, ng);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
